// File: rtl/subdiv_pkg.sv
// subdiv_pkg: shared state encoding and default width for the subtraction divider
package subdiv_pkg;
  localparam int SUBDIV_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, SUB, DONE} subdiv_state_e;
endpackage

// File: rtl/sub_unit.sv
// sub_unit: combinational WIDTH-bit a-b with borrow out
module sub_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/subtraction_divider_ctrl.sv
// subtraction_divider_ctrl: unsigned divide by repeated subtraction, one subtract per clock
// Define SUBDIV_FASTPATH_EN to finish dividend<divisor in IDLE without visiting SUB.
module subtraction_divider_ctrl
  import subdiv_pkg::*;
#(
  parameter int WIDTH = SUBDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  subdiv_state_e    state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvs_q, dvs_d, quo_q, quo_d, res_q, res_d;
  logic             dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  sub_unit #(.WIDTH(WIDTH)) u_sub (
    .a(rem_q),
    .b(dvs_q),
    .diff(diff),
    .borrow_out(borrow)
  );
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: if (start) begin
        rem_d   = dividend;
        dvs_d   = divisor;
        quo_d   = '0;
        dbz_d   = 1'b0;
        state_d = SUB;
        if (divisor == '0) begin
          quo_d   = '1;
          res_d   = dividend;
          dbz_d   = 1'b1;
          state_d = DONE;
        end
`ifdef SUBDIV_FASTPATH_EN
        else if (dividend < divisor) begin
          res_d   = dividend;
          state_d = DONE;
        end
`endif
      end
      SUB: begin
        rem_d   = borrow ? rem_q : diff;
        quo_d   = borrow ? quo_q : quo_q + WIDTH'(1);
        res_d   = borrow ? rem_q : res_q;
        state_d = borrow ? DONE : SUB;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = res_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_subtraction_divider_ctrl.sv
// tb_subtraction_divider_ctrl: scoreboard bench for the subtraction divider
module tb_subtraction_divider_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } exp_t;
  exp_t sb[$];
  subtraction_divider_ctrl dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 4'hF; e.r = 4'(a); e.z = 1'b1; e.lat = 0;
    end else begin
      e.q = 4'(a / b); e.r = 4'(a % b); e.z = 1'b0; e.lat = a / b + 1;
`ifdef SUBDIV_FASTPATH_EN
      if (a < b) e.lat = 0;
`endif
    end
    return e;
  endfunction
  // Returns just after edge E0 with start already released.
  task automatic launch(input int a, input int b);
    @(negedge clk);
    dividend = 4'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  // k counts negedges after E0; k==L is the cycle done should be high. lat=-1 on timeout.
  task automatic wait_done(output int lat, output int busy_n);
    lat = -1;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
      n_bad++;
      $display("FAIL reset_state got busy=%b done=%b q=%h r=%h z=%b want all 0", busy, done, quotient, remainder, div_by_zero);
    end
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_beats_start got busy=%b done=%b want 0 0", busy, done);
    end
  endtask
  task automatic test_divide(input int a, input int b);
    exp_t e;
    int lat, bn;
    launch(a, b);
    wait_done(lat, bn);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++;
      $display("FAIL latency %0d/%0d got %0d want %0d", a, b, lat, e.lat);
    end
    n_cmp++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
      n_bad++;
      $display("FAIL result %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", a, b, quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
    n_cmp++;
    if (bn !== e.lat + 1) begin
      n_bad++;
      $display("FAIL busy_len %0d/%0d got %0d want %0d", a, b, bn, e.lat + 1);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== e.q || remainder !== e.r || div_by_zero !== e.z) begin
      n_bad++;
      $display("FAIL after_done %0d/%0d got done=%b busy=%b q=%0d r=%0d z=%b want 0 0 %0d %0d %b", a, b, done, busy, quotient, remainder, div_by_zero, e.q, e.r, e.z);
    end
  endtask
  task automatic test_dbz_clears();
    test_divide(9, 0);
    launch(5, 3);
    @(negedge clk);
    n_cmp++;
    if (div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL dbz_clear got %b want 0", div_by_zero);
    end
    repeat (6) @(negedge clk);
    void'(sb.pop_front());
  endtask
  task automatic test_ignore_start();
    exp_t e;
    int lat, bn;
    launch(12, 5);
    dividend = 4'd1; divisor = 4'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bn);
    e = sb.pop_front();
    n_cmp++;
    if (lat < 0 || lat + 1 !== e.lat || quotient !== e.q || remainder !== e.r) begin
      n_bad++;
      $display("FAIL ignore_start got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d", lat + 1, quotient, remainder, e.lat, e.q, e.r);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL ignore_requeue got busy=%b want 0", busy);
      end
    end
  endtask
  task automatic test_reset_mid();
    launch(15, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_front());
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
        n_bad++;
        $display("FAIL reset_mid cyc%0d got busy=%b done=%b q=%h r=%h z=%b want all 0", k, busy, done, quotient, remainder, div_by_zero);
      end
    end
    test_divide(6, 3);
  endtask
  task automatic test_random();
    for (int i = 0; i < 8; i++) test_divide(int'($urandom_range(15)), int'($urandom_range(15)));
  endtask
  initial begin
    test_reset();
    test_divide(5, 3);
    test_divide(10, 2);
    test_divide(15, 1);
    test_divide(2, 7);
    test_divide(0, 4);
    test_divide(15, 15);
    test_dbz_clears();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
